// File: rtl/digitron_scan.sv
// -----------------------------------------------------------------------------
// digitron_scan
//   Time-multiplexed scan driver for a 6-digit common-anode seven-segment
//   display. One digit is lit per slot. Each slot starts with a short
//   all-off blanking window to suppress ghosting. The six input nibbles and
//   decimal-point flags are captured once per frame, so a frame never shows a
//   mix of old and new digits.
//
//   Outputs are active low and registered. They lag the internal slot
//   counters by one clock.
// -----------------------------------------------------------------------------
module digitron_scan #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data,
  input  logic [5:0]  dp_en,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  // Clocks per digit slot, and the width of the prescaler that counts them.
  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST  = 3'd5;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'h3F;

  // Hex to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [23:0]      shadow_data;
  logic [5:0]       shadow_dp;

  logic             slot_end;
  logic             frame_start;
  logic             blank;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic [7:0]       seg_d;
  logic [5:0]       sel_d;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (idx == 3'd0) && (cnt == '0);
  assign blank       = (cnt < CNT_BLANK);

  // Prescaler and digit index: the index moves on at the end of each slot
  // and wraps 5 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (slot_end) begin
      // NOTE: state registers use non-blocking assignment so that every
      // always_ff reads the pre-edge values of cnt/idx.
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame latch: capture the digits and dots only at the start of a frame.
  // This cycle is always blanked, so the captured value is in place before
  // digit 0 lights.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (frame_start) begin
      shadow_data <= data;
      shadow_dp   <= dp_en;
    end
  end

  // Pick the nibble and dot of the digit that owns the current slot.
  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    case (idx)
      3'd0: begin cur_nib = shadow_data[3:0];   cur_dp = shadow_dp[0]; end
      3'd1: begin cur_nib = shadow_data[7:4];   cur_dp = shadow_dp[1]; end
      3'd2: begin cur_nib = shadow_data[11:8];  cur_dp = shadow_dp[2]; end
      3'd3: begin cur_nib = shadow_data[15:12]; cur_dp = shadow_dp[3]; end
      3'd4: begin cur_nib = shadow_data[19:16]; cur_dp = shadow_dp[4]; end
      3'd5: begin cur_nib = shadow_data[23:20]; cur_dp = shadow_dp[5]; end
      default: ;
    endcase
  end

  // Next pin values: all off during blanking, otherwise the selected digit.
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    if (!blank) begin
      sel_d = ~(6'b000001 << idx);
      seg_d = {~cur_dp, decode(cur_nib)};
    end
  end

  // Registered pins. On reset they go dark at once, so a half-shown digit is
  // never left on the display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      sel <= SEL_OFF;
    end else begin
      seg <= seg_d;
      sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_digitron_scan.sv
// -----------------------------------------------------------------------------
// tb_digitron_scan
//   Directed bench for digitron_scan with DIV=6, BLANK_CYC=1.
//
//   A time-based model gives the expected seg/sel on every cycle. The model
//   uses the number of clocks since reset release, the slot length and the
//   value latched at each frame boundary. Directed steps also check
//   hand-computed literals.
// -----------------------------------------------------------------------------
module tb_digitron_scan;

  localparam int CLK_FREQ  = 600;
  localparam int SCAN_HZ   = 100;
  localparam int BLANK_CYC = 1;
  localparam int DIV       = CLK_FREQ / SCAN_HZ;
  localparam int FRAME     = 6 * DIV;

  logic        clk;
  logic        rst_n;
  logic [23:0] data;
  logic [5:0]  dp_en;
  logic [7:0]  seg;
  logic [5:0]  sel;

  int checks = 0;
  int errors = 0;

  digitron_scan #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_HZ  (SCAN_HZ),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .dp_en(dp_en),
    .seg  (seg),
    .sel  (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  bit          m_valid = 0;
  int          m_t     = -1;      // clocks since reset release, -1 while in reset
  logic [23:0] m_data  = '0;
  logic [5:0]  m_dp    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_t     <= -1;
    end else if (m_valid) begin
      m_t <= m_t + 1;
      if ((m_t + 1) % FRAME == 0) begin
        m_data <= data;
        m_dp   <= dp_en;
      end
    end
  end

  // Expected {sel, seg} for the output register state after clock t.
  function automatic logic [13:0] expect_out(input int t, input logic [23:0] d,
                                             input logic [5:0] dp);
    int pos;
    int dig;
    logic [3:0] nib;
    if (t < 0) return {6'h3F, 8'hFF};
    pos = t % DIV;
    dig = (t / DIV) % 6;
    if (pos < BLANK_CYC) return {6'h3F, 8'hFF};
    nib = d[dig*4 +: 4];
    return {6'h3F ^ (6'd1 << dig), ~dp[dig], hex7[nib]};
  endfunction

  // Compare DUT outputs against the model on every cycle once reset has
  // been seen.
  always @(negedge clk) begin
    logic [13:0] e;
    if (m_valid) begin
      e = expect_out(m_t, m_data, m_dp);
      check("model_sel", {26'd0, sel}, {26'd0, e[13:8]});
      check("model_seg", {24'd0, seg}, {24'd0, e[7:0]});
    end
  end

  // ---------------------------------------------------------------- directed
  // Wait until the target digit is selected, then check its segment pattern.
  task automatic wait_sel(input logic [5:0] target, input logic [7:0] exp_seg,
                          input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel !== target && n < 4 * FRAME);
    check({name, "_sel"}, {26'd0, sel}, {26'd0, target});
    check({name, "_seg"}, {24'd0, seg}, {24'd0, exp_seg});
  endtask

  logic [5:0] lit_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] lit_seg [6] = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

  initial begin
    rst_n = 1'b0;
    data  = 24'h012345;
    dp_en = 6'h00;

    // 1. Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_sel", {26'd0, sel}, 32'h3F);
      check("rst_seg", {24'd0, seg}, 32'hFF);
      check("rst_cnt", 32'(dut.cnt), 32'd0);
      check("rst_idx", 32'(dut.idx), 32'd0);
    end

    // 2./3. Release reset and walk one complete frame slot by slot.
    rst_n = 1'b1;
    for (int d = 0; d < 6; d++) begin
      for (int p = 0; p < DIV; p++) begin
        @(negedge clk);
        if (p == 0) begin
          check("frame_blank_sel", {26'd0, sel}, 32'h3F);
          check("frame_blank_seg", {24'd0, seg}, 32'hFF);
        end else begin
          check("frame_lit_sel", {26'd0, sel}, {26'd0, lit_sel[d]});
          check("frame_lit_seg", {24'd0, seg}, {24'd0, lit_seg[d]});
        end
      end
    end
    @(negedge clk);
    check("wrap_blank_sel", {26'd0, sel}, 32'h3F);
    @(negedge clk);
    check("wrap_sel", {26'd0, sel}, 32'h3E);
    check("wrap_seg", {24'd0, seg}, 32'h92);

    // 4. New data mid-frame: the rest of this frame keeps the old digits.
    wait_sel(6'h3B, 8'hB0, "mid_d2");
    data = 24'hFEDCBA;
    wait_sel(6'h37, 8'hA4, "old_d3");
    wait_sel(6'h2F, 8'hF9, "old_d4");
    wait_sel(6'h1F, 8'hC0, "old_d5");
    wait_sel(6'h3E, 8'h88, "new_d0");
    wait_sel(6'h3D, 8'h83, "new_d1");
    wait_sel(6'h3B, 8'hC6, "new_d2");
    wait_sel(6'h37, 8'hA1, "new_d3");
    wait_sel(6'h2F, 8'h86, "new_d4");
    wait_sel(6'h1F, 8'h8E, "new_d5");

    // 5. Decimal point on digit 2 only.
    data  = 24'h012345;
    dp_en = 6'b000100;
    wait_sel(6'h3E, 8'h92, "dp_d0");
    wait_sel(6'h3D, 8'h99, "dp_d1");
    wait_sel(6'h3B, 8'h30, "dp_d2");
    wait_sel(6'h37, 8'hA4, "dp_d3");

    // 6. Reset during digit 4: dark at once, restart at digit 0 with new data.
    wait_sel(6'h2F, 8'hF9, "pre_rst_d4");
    rst_n = 1'b0;
    data  = 24'hABCDE7;
    dp_en = 6'h00;
    @(negedge clk);
    check("midrst_sel", {26'd0, sel}, 32'h3F);
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    check("midrst_cnt", 32'(dut.cnt), 32'd0);
    check("midrst_idx", 32'(dut.idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_blank_sel", {26'd0, sel}, 32'h3F);
    for (int p = 1; p < DIV; p++) begin
      @(negedge clk);
      check("restart_d0_sel", {26'd0, sel}, 32'h3E);
      check("restart_d0_seg", {24'd0, seg}, 32'hF8);
    end
    wait_sel(6'h3D, 8'h86, "restart_d1");

    repeat (FRAME) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
